gayle_sector_fifo: RTL and testbench

- Parametrised sector-buffer FIFO between the Gayle IDE register interface and the host-side data port.
- Successor to the fixed 16-bit/4096-word sector FIFO; data width, depth and sector size are now parameters.
- Adds true full/overflow/underflow protection, an occupancy level, a sector count, a synchronous flush and sticky error flags.
- Storage is synchronous block RAM; all state advances only on `clk7_en` cycles.

---
 rtl/gayle_sector_fifo.sv | 117 +++++++++++
 tb/tb_gayle_sector_fifo.sv | 251 +++++++++++++++++++++++++
 2 files changed

// File: rtl/gayle_sector_fifo.sv
// gayle_sector_fifo
//   Sector-buffer FIFO between the Gayle IDE register interface and the
//   host-side data port. Synchronous block RAM storage, all state advances
//   only on clk7_en cycles.
//
// Parameters
//   DATA_W  data word width
//   ADDR_W  log2 of depth in words
//   SECT_W  log2 of words per sector (SECT_W <= ADDR_W, SECT_W >= 1)
//
// Ports
//   clk, reset_n        bus clock, async active-low reset
//   clk7_en             clock enable for every state update
//   clear               synchronous flush (wins over rd/wr)
//   data_in, wr         write port
//   rd                  read strobe
//   data_out            registered read data (word at read pointer)
//   empty, full         status; empty includes a one-cycle write-delay guard
//   sector_ready        at least one sector block between the pointers
//   last                word at read pointer closes a sector
//   level, sectors      occupancy in words / whole sectors
//   overflow, underflow sticky error flags

module gayle_sector_fifo #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 12,
  parameter int SECT_W = 8
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic                   clk7_en,
  input  logic                   clear,
  input  logic [DATA_W-1:0]      data_in,
  input  logic                   wr,
  input  logic                   rd,
  output logic [DATA_W-1:0]      data_out,
  output logic                   empty,
  output logic                   full,
  output logic                   sector_ready,
  output logic                   last,
  output logic [ADDR_W:0]        level,
  output logic [ADDR_W-SECT_W:0] sectors,
  output logic                   overflow,
  output logic                   underflow
);

  localparam logic [ADDR_W:0] PTR_ONE = (ADDR_W+1)'(1);

  logic [DATA_W-1:0] mem [0:(1<<ADDR_W)-1];
  logic [ADDR_W:0]   inptr;
  logic [ADDR_W:0]   outptr;
  logic              empty_rd;
  logic              empty_wr;
  logic              wr_ok;
  logic              rd_ok;

  // Extra pointer MSB separates full (MSBs differ) from empty (all equal).
  assign empty_rd = (inptr == outptr);
  assign full     = (inptr[ADDR_W] != outptr[ADDR_W]) &&
                    (inptr[ADDR_W-1:0] == outptr[ADDR_W-1:0]);
  assign level    = inptr - outptr;
  assign sectors  = level[ADDR_W:SECT_W];

  // empty_wr holds empty high for one extra cycle after the first write so
  // the registered RAM read has time to present the new word.
  assign empty        = empty_rd | empty_wr;
  assign sector_ready = (inptr[ADDR_W:SECT_W] != outptr[ADDR_W:SECT_W]);
  assign last         = (&outptr[SECT_W-1:0]) & ~empty_rd;

  // Both strobes are judged against pre-edge flags.
  assign wr_ok = wr & ~full;
  assign rd_ok = rd & ~empty_rd;

  // RAM write port, no reset so it maps onto block RAM.
  always_ff @(posedge clk) begin
    if (clk7_en && !clear && wr_ok)
      mem[inptr[ADDR_W-1:0]] <= data_in;
  end

  // Registered read of the pre-increment read pointer; same-address
  // read-during-write returns the old contents.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)
      data_out <= '0;
    else if (clk7_en && !clear)
      data_out <= mem[outptr[ADDR_W-1:0]];
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      inptr     <= '0;
      outptr    <= '0;
      empty_wr  <= 1'b1;
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else if (clk7_en) begin
      if (clear) begin
        inptr     <= '0;
        outptr    <= '0;
        empty_wr  <= 1'b1;
        overflow  <= 1'b0;
        underflow <= 1'b0;
      end else begin
        if (wr_ok)
          inptr <= inptr + PTR_ONE;
        if (wr && full)
          overflow <= 1'b1;
        if (rd_ok)
          outptr <= outptr + PTR_ONE;
        if (rd && empty_rd)
          underflow <= 1'b1;
        empty_wr <= empty_rd;
      end
    end
  end

endmodule

// File: tb/tb_gayle_sector_fifo.sv
module tb_gayle_sector_fifo;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        clk7_en = 1'b1;
  logic        clear = 1'b0;
  logic [15:0] data_in = '0;
  logic        wr = 1'b0;
  logic        rd = 1'b0;
  logic [15:0] data_out;
  logic        empty, full, sector_ready, last, overflow, underflow;
  logic [12:0] level;
  logic [4:0]  sectors;

  gayle_sector_fifo #(.DATA_W(16), .ADDR_W(12), .SECT_W(8)) dut (
    .clk(clk), .reset_n(reset_n), .clk7_en(clk7_en), .clear(clear),
    .data_in(data_in), .wr(wr), .rd(rd), .data_out(data_out),
    .empty(empty), .full(full), .sector_ready(sector_ready), .last(last),
    .level(level), .sectors(sectors), .overflow(overflow), .underflow(underflow)
  );

  always #5 clk = ~clk;

  int unsigned n_vec = 0;
  int unsigned n_err = 0;

  // model state
  int unsigned mi = 0, mo = 0;
  bit          m_ewr = 1'b1, m_ovf = 1'b0, m_unf = 1'b0;
  logic [15:0] mq[$];     // words stored in the FIFO
  logic [15:0] exp_q[$];  // words expected on data_out after a read edge
  logic        rd_chk = 1'b0;
  logic        chk_pend = 1'b0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic int unsigned mlvl();
    return (mi - mo) & 32'd8191;
  endfunction

  task automatic check_all(input string tag);
    int unsigned l;
    l = mlvl();
    chk({tag, ".level"}, 32'(level), l);
    chk({tag, ".empty"}, 32'(empty), 32'((l == 0) || m_ewr));
    chk({tag, ".full"}, 32'(full), 32'(l == 4096));
    chk({tag, ".sectors"}, 32'(sectors), l >> 8);
    chk({tag, ".sector_ready"}, 32'(sector_ready), 32'((mi >> 8) != (mo >> 8)));
    chk({tag, ".last"}, 32'(last), 32'(((mo & 255) == 255) && (l != 0)));
    chk({tag, ".overflow"}, 32'(overflow), 32'(m_ovf));
    chk({tag, ".underflow"}, 32'(underflow), 32'(m_unf));
  endtask

  // One clock with the given strobes; model updated against pre-edge state.
  task automatic step(input bit en, input bit w, input bit r, input bit clr,
                      input logic [15:0] d);
    int unsigned l;
    bit racc, wacc;
    l = mlvl();
    clk7_en = en; wr = w; rd = r; clear = clr; data_in = d; rd_chk = 1'b0;
    if (en) begin
      if (clr) begin
        mi = 0; mo = 0; m_ewr = 1'b1; m_ovf = 1'b0; m_unf = 1'b0;
        mq.delete();
      end else begin
        racc = r && (l != 0);
        wacc = w && (l != 4096);
        if (w && !wacc) m_ovf = 1'b1;
        if (r && !racc) m_unf = 1'b1;
        if (racc) begin
          exp_q.push_back(mq.pop_front());
          rd_chk = 1'b1;
          mo = (mo + 1) & 32'd8191;
        end
        if (wacc) begin
          mq.push_back(d);
          mi = (mi + 1) & 32'd8191;
        end
        m_ewr = (l == 0);
      end
    end
    @(posedge clk);
    #1;
    wr = 1'b0; rd = 1'b0; clear = 1'b0; clk7_en = 1'b1; rd_chk = 1'b0;
  endtask

  // Scoreboard monitor: a read edge presents the popped word on data_out.
  always @(posedge clk) chk_pend <= rd_chk;

  always @(negedge clk) begin
    if (chk_pend) begin
      n_vec++;
      if (exp_q.size() == 0) begin
        n_err++;
        $display("FAIL data_out: got %0h with no expected word queued at %0t", data_out, $time);
      end else begin
        logic [15:0] e;
        e = exp_q.pop_front();
        if (data_out !== e) begin
          n_err++;
          $display("FAIL data_out: got %0h expected %0h at %0t", data_out, e, $time);
        end
      end
    end
  end

  initial begin
    int unsigned wc, i, l;
    bit w, r;

    // reset state
    #3;
    check_all("reset");
    chk("reset.data_out", 32'(data_out), 32'h0);
    #5 reset_n = 1'b1;

    // first write / empty guard / first read
    step(1, 1, 0, 0, 16'h1234);
    check_all("wr1");
    chk("wr1.empty_guard", 32'(empty), 32'd1);
    step(1, 0, 0, 0, 16'h0);
    check_all("wr1_idle");
    chk("wr1.empty_fall", 32'(empty), 32'd0);
    step(1, 0, 1, 0, 16'h0);
    check_all("rd1");
    chk("rd1.empty_rise", 32'(empty), 32'd1);

    // sector hysteresis
    step(1, 0, 0, 1, 16'h0);
    check_all("clr1");
    for (int k = 0; k < 256; k++) begin
      step(1, 1, 0, 0, 16'(k * 3 + 16'h0100));
      check_all("sect_wr");
    end
    chk("sect.sr_up", 32'(sector_ready), 32'd1);
    chk("sect.sectors", 32'(sectors), 32'd1);
    for (int k = 0; k < 255; k++) begin
      step(1, 0, 1, 0, 16'h0);
      check_all("sect_rd");
    end
    chk("sect.last", 32'(last), 32'd1);
    chk("sect.sr_hold", 32'(sector_ready), 32'd1);
    step(1, 0, 1, 0, 16'h0);
    check_all("sect_rd_last");
    chk("sect.sr_down", 32'(sector_ready), 32'd0);

    // full / overflow
    step(1, 0, 0, 1, 16'h0);
    for (int k = 0; k < 4096; k++) begin
      step(1, 1, 0, 0, 16'(k ^ 16'hA5C3));
      if (k % 256 == 255) check_all("fill");
    end
    chk("full.full", 32'(full), 32'd1);
    chk("full.level", 32'(level), 32'd4096);
    chk("full.sectors", 32'(sectors), 32'd16);
    step(1, 1, 0, 0, 16'hDEAD);
    check_all("ovf_wr");
    chk("ovf.flag", 32'(overflow), 32'd1);
    step(1, 1, 1, 0, 16'hBEEF);
    check_all("ovf_rdwr");
    chk("ovf_rdwr.level", 32'(level), 32'd4095);

    // underflow
    step(1, 0, 0, 1, 16'h0);
    step(1, 0, 1, 0, 16'h0);
    check_all("unf_rd");
    chk("unf.flag", 32'(underflow), 32'd1);
    step(1, 1, 1, 0, 16'h7777);
    check_all("unf_rdwr");
    chk("unf_rdwr.level", 32'(level), 32'd1);
    step(1, 0, 1, 0, 16'h0);
    check_all("unf_drain");

    // wrap streaming
    step(1, 0, 0, 1, 16'h0);
    wc = 0;
    i = 0;
    while (wc < 10000 && i < 40000) begin
      l = mlvl();
      w = (l < 280) && ((i % 4) != 3);
      r = ((i % 3) != 0) || (l >= 280);
      step(1, w, r, 0, 16'((wc * 32'h9E37) ^ 32'h5A5A));
      if (w && l != 4096) wc++;
      check_all("wrap");
      chk("wrap.level_max", 32'(level <= 300), 32'd1);
      i++;
    end
    chk("wrap.done", wc, 32'd10000);
    i = 0;
    while (mlvl() != 0 && i < 400) begin
      step(1, 0, 1, 0, 16'h0);
      check_all("wrap_drain");
      i++;
    end

    // clear at level 300 with overflow set
    step(1, 0, 0, 1, 16'h0);
    for (int k = 0; k < 4097; k++)
      step(1, 1, 0, 0, 16'(k + 7));
    for (int k = 0; k < 3796; k++)
      step(1, 0, 1, 0, 16'h0);
    check_all("pre_clear");
    chk("pre_clear.level", 32'(level), 32'd300);
    chk("pre_clear.ovf", 32'(overflow), 32'd1);
    step(1, 0, 0, 1, 16'h0);
    check_all("clear");
    chk("clear.level", 32'(level), 32'd0);
    chk("clear.empty", 32'(empty), 32'd1);
    chk("clear.ovf", 32'(overflow), 32'd0);
    chk("clear.sr", 32'(sector_ready), 32'd0);

    // clock-enable gating
    step(1, 1, 0, 0, 16'h1111);
    step(1, 1, 0, 0, 16'h2222);
    step(0, 1, 1, 0, 16'h3333);
    check_all("gate1");
    step(0, 0, 1, 1, 16'h0);
    check_all("gate2");
    chk("gate.level", 32'(level), 32'd2);
    step(1, 0, 1, 0, 16'h0);
    check_all("gate_rd");

    // reset mid-stream, outputs checked with no clock edge
    step(1, 1, 0, 0, 16'h4444);
    #2 reset_n = 1'b0;
    #1;
    mi = 0; mo = 0; m_ewr = 1'b1; m_ovf = 1'b0; m_unf = 1'b0;
    mq.delete();
    check_all("rst_mid");
    chk("rst_mid.data_out", 32'(data_out), 32'h0);
    #2 reset_n = 1'b1;
    step(1, 1, 0, 0, 16'hCAFE);
    step(1, 0, 0, 0, 16'h0);
    step(1, 0, 1, 0, 16'h0);
    check_all("post_rst");

    step(1, 0, 0, 0, 16'h0);
    step(1, 0, 0, 0, 16'h0);
    chk("scoreboard_drained", 32'(exp_q.size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
